// File: rtl/ysyx_22050078_ifu_axi_pkg.sv
// Shared definitions for the AXI instruction fetch unit: FSM states,
// the NOP substituted on faults, and the fetch-error bit positions.
package ysyx_22050078_ifu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int ERR_BIT_MISALIGN = 0;
  localparam int ERR_BIT_BUS      = 1;

endpackage

// File: rtl/ysyx_22050078_ifu_axi_if.sv
// Signal bundle between the fetch unit, the PC unit, the read channel of
// the memory bus and the decoder.
interface ysyx_22050078_ifu_axi_if #(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
);
  // Every channel transfers on a rising edge where its valid and ready are
  // both high; a source holds valid and payload until that edge.
  logic [PC_WIDTH-1:0]   i_pc;
  logic                  i_pc_valid;
  logic                  o_pc_ready;
  logic                  i_flush;
  logic [PC_WIDTH-1:0]   o_araddr;
  logic                  o_arvalid;
  logic                  i_arready;
  logic [BUS_WIDTH-1:0]  i_rdata;
  logic [1:0]            i_rresp;
  logic                  i_rvalid;
  logic                  o_rready;
  logic [INST_WIDTH-1:0] o_inst;
  logic [PC_WIDTH-1:0]   o_inst_pc;
  logic                  o_inst_valid;
  logic                  i_inst_ready;
  logic [1:0]            o_fetch_err;

  modport master (
    input  i_pc, i_pc_valid, i_flush, i_arready, i_rdata, i_rresp, i_rvalid, i_inst_ready,
    output o_pc_ready, o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_inst_valid, o_fetch_err
  );

  modport slave (
    output i_pc, i_pc_valid, i_flush, i_arready, i_rdata, i_rresp, i_rvalid, i_inst_ready,
    input  o_pc_ready, o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_inst_valid, o_fetch_err
  );
endinterface

// File: rtl/ysyx_22050078_ifu_wordsel.sv
// Picks the 32-bit instruction word out of a 64-bit read beat.
module ysyx_22050078_ifu_wordsel #(
  parameter int BUS_WIDTH  = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0]  beat,
  input  logic                  sel,
  output logic [INST_WIDTH-1:0] word
);
  assign word = sel ? beat[BUS_WIDTH-1:BUS_WIDTH-INST_WIDTH] : beat[INST_WIDTH-1:0];
endmodule

// File: rtl/ysyx_22050078_ifu_axi.sv
// Single-outstanding instruction fetch unit: accepts a PC, reads the aligned
// 64-bit beat over AXI read channels and hands one instruction to decode.
module ysyx_22050078_ifu_axi
  import ysyx_22050078_ifu_axi_pkg::*;
#(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22050078_ifu_axi_if.master  bus,
  output state_t                   dbg_state
);

  state_t                state_q, state_n;
  logic [PC_WIDTH-1:0]   pc_q, pc_n;
  logic [INST_WIDTH-1:0] inst_q, inst_n;
  logic [1:0]            err_q, err_n;
  logic                  flushed_q, flushed_n;
  logic [INST_WIDTH-1:0] beat_word;

  ysyx_22050078_ifu_wordsel #(
    .BUS_WIDTH (BUS_WIDTH),
    .INST_WIDTH(INST_WIDTH)
  ) u_wordsel (
    .beat(bus.i_rdata),
    .sel (pc_q[2]),
    .word(beat_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      err_q     <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      inst_q    <= inst_n;
      err_q     <= err_n;
      flushed_q <= flushed_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    inst_n    = inst_q;
    err_n     = err_q;
    flushed_n = flushed_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_pc_valid && !bus.i_flush) begin
          pc_n      = bus.i_pc;
          flushed_n = 1'b0;
          err_n     = 2'b00;
          if (bus.i_pc[1:0] != 2'b00) begin
            inst_n                  = NOP_INST;
            err_n[ERR_BIT_MISALIGN] = 1'b1;
            state_n                 = S_OUT;
          end else begin
            state_n = S_AR;
          end
        end
      end
      S_AR: begin
        // A flush cannot retract an offered address; remember it and drain the beat.
        if (bus.i_flush) flushed_n = 1'b1;
        if (bus.i_arready) state_n = (bus.i_flush || flushed_q) ? S_DRAIN : S_R;
      end
      S_R: begin
        if (bus.i_rvalid) begin
          if (bus.i_flush) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_OUT;
            if (bus.i_rresp != 2'b00) begin
              inst_n             = NOP_INST;
              err_n[ERR_BIT_BUS] = 1'b1;
            end else begin
              inst_n = beat_word;
            end
          end
        end else if (bus.i_flush) begin
          state_n = S_DRAIN;
        end
      end
      S_OUT: begin
        if (bus.i_flush || bus.i_inst_ready) state_n = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.i_rvalid) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.o_pc_ready   = (state_q == S_IDLE) && !bus.i_flush;
  assign bus.o_arvalid    = (state_q == S_AR);
  assign bus.o_araddr     = {pc_q[PC_WIDTH-1:3], 3'b000};
  assign bus.o_rready     = (state_q == S_R) || (state_q == S_DRAIN);
  assign bus.o_inst_valid = (state_q == S_OUT);
  assign bus.o_inst       = inst_q;
  assign bus.o_inst_pc    = pc_q;
  assign bus.o_fetch_err  = err_q;
  assign dbg_state        = state_q;

endmodule
